mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have clock and reset: one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: start  in  1  EX-stage M-instruction valid; mdu_op  in  3  funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-004 SHALL have ports: op0, op1  in  XLEN(32) each  bypassed operands from the forwarding network; rd_ex  in  5  destination index.
REQ-005 SHALL have ports: flush  in  1  pipeline kill; stall_ex2  in  1  downstream hold.
REQ-006 SHALL have ports: busy  out  1  stall request to DC/EX; wreg_en_ex2  out  1  result valid with write enable; rd_ex2  out  5; wreg_data_ex2  out  32  result.

Function
REQ-007 SHALL register a multiply result one cycle after start: wreg_en_ex2=1 and wreg_data_ex2 valid for exactly one cycle.
REQ-008 SHALL compute a 64-bit product and return the low word for MUL, the high word signed×signed for MULH, signed×unsigned for MULHSU, and unsigned×unsigned for MULHU.
REQ-009 SHALL implement divide as FSM IDLE -> DIV_RUN -> DIV_DONE -> IDLE.
REQ-010 SHALL run 32 radix-2 restoring iterations in DIV_RUN, one per cycle, tracked by a 5-bit counter.
REQ-011 SHALL fix divide latency at 34 cycles from start to wreg_en_ex2.
REQ-012 SHALL assert busy from the start cycle through DIV_RUN.
REQ-013 SHALL deassert busy in the DIV_DONE cycle.
REQ-014 SHALL operate signed divides on magnitudes and then fix the sign: quotient negative iff the operand signs differ and the divisor is nonzero; remainder takes the dividend's sign.
REQ-015 SHALL, on divide by zero, bypass iteration and finish next cycle with quotient 0xFFFFFFFF and remainder = op0, for both signed and unsigned ops.
REQ-016 SHALL, on signed overflow (0x80000000 / 0xFFFFFFFF), finish next cycle with quotient 0x80000000 and remainder 0.
REQ-017 SHALL ignore start while busy=1.
REQ-018 SHALL treat start and flush in the same cycle as flush: nothing is issued.
REQ-019 SHALL, on flush in any state, return to IDLE next cycle with wreg_en_ex2=0 and busy=0, and drop any pending result.
REQ-020 SHALL, while stall_ex2=1, hold all outputs and freeze the iteration counter.
REQ-021 SHALL treat rd_ex=0 as a normal operation and suppress wreg_en_ex2.

Reset
REQ-022 SHALL, when rst=1 at a clock edge, set state=IDLE, counter=0, busy=0, wreg_en_ex2=0, rd_ex2=0, wreg_data_ex2=0.
REQ-023 SHALL let reset override flush, stall_ex2 and start, and abort an in-flight divide with no result emitted.

Configuration
REQ-024 SHALL, with MDU_DIV_EN defined, include the divider FSM and REQ-009 to REQ-016.
REQ-025 SHALL, with MDU_DIV_EN undefined, remove the divider and keep busy constant 0.
REQ-026 SHALL, with MDU_DIV_EN undefined, treat DIV/DIVU/REM/REMU as one-cycle operations returning wreg_en_ex2=1 with data 0; the decoder traps these.

Structure
REQ-027 SHALL place the mdu_op encodings, the FSM state encodings and the divider iteration count (32) in the shared params.v definitions.
REQ-028 SHALL put the divider in its own sub-module, mdu_divider (start/done handshake, abort input), instantiated only under MDU_DIV_EN.

Verification
REQ-029 SHALL verify MULH: op0=0xFFFFFFFF, op1=0xFFFFFFFF -> next cycle wreg_data_ex2=0x00000000; MULHU with the same operands -> 0xFFFFFFFE.
REQ-030 SHALL verify DIV: op0=-7, op1=2 -> busy for 33 cycles, then quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-031 SHALL verify DIVU: op1=0, op0=0x1234 -> result after 2 cycles, quotient 0xFFFFFFFF; REMU -> 0x1234.
REQ-032 SHALL verify DIV: 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, busy for 1 cycle only.
REQ-033 SHALL verify flush at iteration 10 of a divide -> busy=0 next cycle and no wreg_en_ex2 pulse; a following MUL 3×5 -> 15 after 1 cycle.
REQ-034 SHALL verify rst at iteration 20 -> all outputs 0; a following start is accepted normally.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared funct3 encodings, divider FSM states and iteration count
package mul_div_unit_pkg;
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;
    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} div_state_e;
    localparam int DIV_ITERS = 32;
endpackage

// File: rtl/mul_div_unit_divider.sv
// mdu_divider: 32-step restoring divider with sign fixup; divide-by-zero and signed
// overflow skip the iteration and finish the cycle after start.
module mdu_divider
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        abort,
    input  logic        hold,
    input  logic        start,
    input  logic        is_signed,
    input  logic        is_rem,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        running,
    output logic        done,
    output logic        idle,
    output logic [31:0] result
);
    div_state_e  state, state_nx;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, dvs, a_mag, b_mag, rem_sh;
    logic [32:0] trial;
    logic        neg_q, neg_r, rem_sel, by_zero, ovf;

    assign a_mag   = (is_signed && dividend[31]) ? -dividend : dividend;
    assign b_mag   = (is_signed && divisor[31]) ? -divisor : divisor;
    assign by_zero = divisor == '0;
    assign ovf     = is_signed && dividend == 32'h8000_0000 && divisor == '1;
    assign rem_sh  = {rem[30:0], quo[31]};
    assign trial   = {rem, quo[31]} - {1'b0, dvs};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (by_zero || ovf) ? DIV_DONE : DIV_RUN;
            DIV_RUN: if (cnt == 5'(DIV_ITERS - 1)) state_nx = DIV_DONE;
            default: state_nx = IDLE;
        endcase
        if (hold) state_nx = state;
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != DIV_RUN) ? '0 : (state == DIV_RUN && !hold) ? cnt + 5'd1 : cnt;
        end
    end

    // Quotient bits shift in from the bottom while the dividend magnitude shifts out the top.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            quo     <= by_zero ? '1 : ovf ? 32'h8000_0000 : a_mag;
            rem     <= by_zero ? dividend : '0;
            dvs     <= b_mag;
            neg_q   <= is_signed && !by_zero && !ovf && (dividend[31] ^ divisor[31]);
            neg_r   <= is_signed && !by_zero && dividend[31];
            rem_sel <= is_rem;
        end else if (state == DIV_RUN && !hold) begin
            quo <= {quo[30:0], !trial[32]};
            rem <= trial[32] ? rem_sh : trial[31:0];
        end
    end

    assign result  = rem_sel ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
    assign running = state == DIV_RUN;
    assign done    = state == DIV_DONE;
    assign idle    = state == IDLE;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: single-cycle RV32M multiplier plus optional 34-cycle divider.
// Define MDU_DIV_EN to build the divider; otherwise divide ops return 0 in one cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] op0,
    input  logic [31:0] op1,
    input  logic [4:0]  rd_ex,
    input  logic        flush,
    input  logic        stall_ex2,
    output logic        busy,
    output logic        wreg_en_ex2,
    output logic [4:0]  rd_ex2,
    output logic [31:0] wreg_data_ex2
);
    logic               issue, res_en;
    logic [32:0]        mul_a, mul_b;
    logic signed [63:0] prod;
    logic [31:0]        mul_res, res_data;
    logic [4:0]         res_rd;

    assign mul_a   = {mdu_op != OP_MULHU && op0[31], op0};
    assign mul_b   = {(mdu_op == OP_MUL || mdu_op == OP_MULH) && op1[31], op1};
    assign prod    = 64'($signed(mul_a)) * 64'($signed(mul_b));
    assign mul_res = (mdu_op == OP_MUL) ? prod[31:0] : prod[63:32];

`ifdef MDU_DIV_EN
    logic        div_start, div_run, div_done, div_idle;
    logic [31:0] div_res;
    logic [4:0]  rd_q;

    // A start seen while the divider is occupied is the same stalled instruction; drop it.
    assign issue     = start && !flush && !stall_ex2 && div_idle;
    assign div_start = issue && mdu_op[2];
    assign busy      = div_run || div_start;

    mdu_divider u_div (
        .clk       (clk),
        .rst       (rst),
        .abort     (flush),
        .hold      (stall_ex2),
        .start     (div_start),
        .is_signed (!mdu_op[0]),
        .is_rem    (mdu_op[1]),
        .dividend  (op0),
        .divisor   (op1),
        .running   (div_run),
        .done      (div_done),
        .idle      (div_idle),
        .result    (div_res)
    );

    always_ff @(posedge clk) if (div_start) rd_q <= rd_ex;

    assign res_en   = div_done || (issue && !mdu_op[2]);
    assign res_rd   = div_done ? rd_q : rd_ex;
    assign res_data = div_done ? div_res : mul_res;
`else
    assign issue    = start && !flush && !stall_ex2;
    assign busy     = 1'b0;
    assign res_en   = issue;
    assign res_rd   = rd_ex;
    assign res_data = mdu_op[2] ? '0 : mul_res;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wreg_en_ex2   <= 1'b0;
            rd_ex2        <= '0;
            wreg_data_ex2 <= '0;
        end else if (flush) begin
            wreg_en_ex2 <= 1'b0;
        end else if (!stall_ex2) begin
            wreg_en_ex2 <= res_en && res_rd != '0;
            if (res_en) begin
                rd_ex2        <= res_rd;
                wreg_data_ex2 <= res_data;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed table, corner sequences and random ops against a reference model.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

`ifdef MDU_DIV_EN
    localparam bit DIV_BUILD = 1'b1;
`else
    localparam bit DIV_BUILD = 1'b0;
`endif

    logic        clk = 0, rst = 1, start = 0, flush = 0, stall_ex2 = 0;
    logic [2:0]  mdu_op = '0;
    logic [31:0] op0 = '0, op1 = '0;
    logic [4:0]  rd_ex = '0;
    logic        busy, wreg_en_ex2;
    logic [4:0]  rd_ex2;
    logic [31:0] wreg_data_ex2;

    int vectors = 0, errors = 0;

    mul_div_unit dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mdu_op        (mdu_op),
        .op0           (op0),
        .op1           (op1),
        .rd_ex         (rd_ex),
        .flush         (flush),
        .stall_ex2     (stall_ex2),
        .busy          (busy),
        .wreg_en_ex2   (wreg_en_ex2),
        .rd_ex2        (rd_ex2),
        .wreg_data_ex2 (wreg_data_ex2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a)), sb = longint'($signed(b));
        longint ua = {32'd0, a}, ub = {32'd0, b};
        logic [63:0] p;
        logic ovf = a == 32'h8000_0000 && b == '1;
        if (op[2] && !DIV_BUILD) return '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? '1 : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? '1 : 32'(ua / ub);
            3'd6: return (b == 0) ? a : ovf ? '0 : 32'(sa % sb);
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2] || !DIV_BUILD) return 1;
        if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == '1)) return 2;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Issues one op for one cycle; latency counts cycles from start to the result pulse.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output int lat, output int bcnt, output logic [31:0] data, output logic [4:0] rdo);
        lat = -1; bcnt = 0; data = '0; rdo = '0;
        @(negedge clk);
        start = 1; mdu_op = op; op0 = a; op1 = b; rd_ex = rd;
        #1 if (busy) bcnt++;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (wreg_en_ex2) begin lat = c; data = wreg_data_ex2; rdo = rd_ex2; end
            else if (busy) bcnt++;
            start = 0;
        end
    endtask

    task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
        int lat, bcnt;
        logic [31:0] data;
        logic [4:0] rdo;
        do_op(op, a, b, rd, lat, bcnt, data, rdo);
        check({name, " data"}, data, exp);
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy cycles"}, bcnt, exp_lat - 1);
        check({name, " rd"}, {27'd0, rdo}, {27'd0, rd});
        @(negedge clk);
        check({name, " one-cycle pulse"}, {31'd0, wreg_en_ex2}, 32'd0);
    endtask

    initial begin
        vec_t tbl[$];
        int lat, pulses;
        logic [31:0] last;

        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 0);
        check("reset en", {31'd0, wreg_en_ex2}, 0);
        check("reset rd", {27'd0, rd_ex2}, 0);
        check("reset data", wreg_data_ex2, 0);
        rst = 0;

        tbl.push_back(vec_t'{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1});
        tbl.push_back(vec_t'{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1});
        tbl.push_back(vec_t'{OP_MUL,    32'd3,         32'd5,         32'd15,        1});
        tbl.push_back(vec_t'{OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1});
        tbl.push_back(vec_t'{OP_MUL,    32'h8000_0000, 32'd2,         32'd0,         1});
        tbl.push_back(vec_t'{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34});
        tbl.push_back(vec_t'{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34});
        tbl.push_back(vec_t'{OP_DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 2});
        tbl.push_back(vec_t'{OP_REMU,   32'h0000_1234, 32'd0,         32'h0000_1234, 2});
        tbl.push_back(vec_t'{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2});
        tbl.push_back(vec_t'{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2});
        tbl.push_back(vec_t'{OP_DIV,    32'd7,         32'd0,         32'hFFFF_FFFF, 2});
        tbl.push_back(vec_t'{OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 2});
        tbl.push_back(vec_t'{OP_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34});
        tbl.push_back(vec_t'{OP_REMU,   32'd100,       32'd7,         32'd2,         34});
        tbl.push_back(vec_t'{OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34});
        tbl.push_back(vec_t'{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34});
        foreach (tbl[i]) begin
            if (tbl[i].op[2] && !DIV_BUILD) run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1), '0, 1);
            else run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1), tbl[i].exp, tbl[i].lat);
        end

        // rd_ex = 0: computed but not written back
        @(negedge clk); start = 1; mdu_op = OP_MUL; op0 = 6; op1 = 7; rd_ex = 0;
        @(negedge clk); start = 0;
        check("rd0 en", {31'd0, wreg_en_ex2}, 0);
        check("rd0 data", wreg_data_ex2, 42);

        // start and flush together: nothing issued
        @(negedge clk); start = 1; flush = 1; mdu_op = OP_MUL; op0 = 4; op1 = 4; rd_ex = 7;
        pulses = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); start = 0; flush = 0;
            if (wreg_en_ex2) pulses++;
        end
        check("start+flush pulses", pulses, 0);

        // stall holds a multiply result
        @(negedge clk); start = 1; mdu_op = OP_MUL; op0 = 9; op1 = 9; rd_ex = 3;
        @(negedge clk); start = 0; stall_ex2 = 1;
        check("stall en", {31'd0, wreg_en_ex2}, 1);
        repeat (2) begin
            @(negedge clk);
            check("stall hold en", {31'd0, wreg_en_ex2}, 1);
            check("stall hold data", wreg_data_ex2, 81);
        end
        stall_ex2 = 0;
        @(negedge clk);
        check("stall release", {31'd0, wreg_en_ex2}, 0);

        // stall freezes a divide for five cycles
        @(negedge clk); start = 1; mdu_op = OP_DIV; op0 = 1000; op1 = 3; rd_ex = 4;
        lat = -1; last = '0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk); start = 0;
            if (wreg_en_ex2 && lat < 0) begin lat = c; last = wreg_data_ex2; end
            stall_ex2 = c >= 5 && c < 10;
        end
        stall_ex2 = 0;
        check("div stall latency", lat, DIV_BUILD ? 39 : 1);
        check("div stall data", last, DIV_BUILD ? 333 : 0);

        // start while busy is ignored
        @(negedge clk); start = 1; mdu_op = OP_DIV; op0 = 50; op1 = 5; rd_ex = 8;
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (wreg_en_ex2) begin pulses++; last = wreg_data_ex2; end
            start = c == 5;
            mdu_op = OP_MUL; op0 = 2; op1 = 3; rd_ex = 9;
        end
        check("busy start pulses", pulses, DIV_BUILD ? 1 : 2);
        check("busy start data", last, DIV_BUILD ? 10 : 6);

        // flush at iteration 10
        @(negedge clk); start = 1; mdu_op = OP_DIV; op0 = 100; op1 = 7; rd_ex = 5;
        pulses = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk); start = 0;
            if (wreg_en_ex2) pulses++;
            if (c == 12) begin
                check("flush busy", {31'd0, busy}, 0);
                check("flush en", {31'd0, wreg_en_ex2}, 0);
            end
            flush = c == 11;
        end
        check("flush pulses", pulses, DIV_BUILD ? 0 : 1);
        run_check("post-flush mul", OP_MUL, 3, 5, 2, 15, 1);

        // reset at iteration 20
        @(negedge clk); start = 1; mdu_op = OP_DIV; op0 = 100; op1 = 7; rd_ex = 6;
        pulses = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk); start = 0;
            if (c == 22) begin
                check("rst busy", {31'd0, busy}, 0);
                check("rst en", {31'd0, wreg_en_ex2}, 0);
                check("rst rd", {27'd0, rd_ex2}, 0);
                check("rst data", wreg_data_ex2, 0);
            end
            if (c >= 22 && wreg_en_ex2) pulses++;
            rst = c == 21;
        end
        check("rst pulses", pulses, 0);
        run_check("post-rst div", OP_DIV, 100, 7, 6, DIV_BUILD ? 14 : 0, DIV_BUILD ? 34 : 1);

        for (int i = 0; i < 150; i++) begin
            logic [2:0] op = 3'($urandom_range(0, 7));
            logic [31:0] a = pick(), b = pick();
            run_check($sformatf("rand%0d op%0d %h,%h", i, op, a, b), op, a, b,
                      5'($urandom_range(1, 31)), ref_model(op, a, b), ref_lat(op, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
